// File: rtl/filter_pkg.sv
// Shared types and helpers for the moving average filter slice.
package filter_pkg;

    typedef enum logic {FILLING, RUNNING} state_t;

    localparam int MAX_WINDOW_LOG2 = 6;

    function automatic int sum_width(input int data_width, input int window_log2);
        return data_width + window_log2;
    endfunction

    // Round half up before the divide-by-window shift.
    function automatic logic [31:0] round_shift(input logic [31:0] value, input int shift);
        return (value + (32'd1 << (shift - 1))) >> shift;
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Circular store of the last 2^WINDOW_LOG2 samples; exposes the entry about to be overwritten.
module sample_ring_buffer #(
    parameter int DATA_WIDTH  = 4,
    parameter int WINDOW_LOG2 = 2
) (
    input  logic                  clk_fpga,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] oldest
);

    localparam int DEPTH = 1 << WINDOW_LOG2;

    logic [DATA_WIDTH-1:0]  entries [DEPTH];
    logic [WINDOW_LOG2-1:0] wr_ptr;

    assign oldest = entries[wr_ptr];

    // The pointer wraps on its own width, so the slot it names is always the oldest one.
    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            entries[wr_ptr] <= wr_data;
            wr_ptr          <= wr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/moving_average_filter.sv
// Rounded running average over the last 2^WINDOW_LOG2 strobed samples.
module moving_average_filter
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int WINDOW_LOG2 = 2
) (
    input  logic                              clk_fpga,
    input  logic                              reset_n,
    input  logic [DATA_WIDTH-1:0]             i_dado,
    input  logic                              i_dado_valido,
    input  logic                              i_clear,
    output logic [DATA_WIDTH-1:0]             o_media,
    output logic                              o_media_valida,
    output logic [DATA_WIDTH+WINDOW_LOG2-1:0] o_soma,
    output logic                              o_janela_cheia
);

    localparam int SUM_WIDTH = sum_width(DATA_WIDTH, WINDOW_LOG2);
    localparam logic [WINDOW_LOG2:0] WINDOW = {1'b1, {WINDOW_LOG2{1'b0}}};

    state_t                 state;
    logic [WINDOW_LOG2:0]   fill_cnt;
    logic [SUM_WIDTH-1:0]   sum;
    logic [SUM_WIDTH-1:0]   sum_next;
    logic [DATA_WIDTH-1:0]  oldest;
    logic [DATA_WIDTH-1:0]  media_next;
    logic                   accept;

    assign accept = i_dado_valido && !i_clear;

    sample_ring_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_ring (
        .clk_fpga (clk_fpga),
        .reset_n  (reset_n),
        .wr_en    (accept),
        .clear    (i_clear),
        .wr_data  (i_dado),
        .oldest   (oldest)
    );

    // The buffer holds exactly the summed samples, so add-new/subtract-oldest never wraps.
    assign sum_next   = sum + SUM_WIDTH'(i_dado) - SUM_WIDTH'(oldest);
    assign media_next = DATA_WIDTH'(round_shift(32'(sum_next), WINDOW_LOG2));

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            state          <= FILLING;
            fill_cnt       <= '0;
            sum            <= '0;
            o_media        <= '0;
            o_media_valida <= 1'b0;
            o_soma         <= '0;
            o_janela_cheia <= 1'b0;
        end else if (i_clear) begin
            state          <= FILLING;
            fill_cnt       <= '0;
            sum            <= '0;
            o_media        <= '0;
            o_media_valida <= 1'b0;
            o_soma         <= '0;
            o_janela_cheia <= 1'b0;
        end else if (accept) begin
            sum            <= sum_next;
            o_soma         <= sum_next;
            o_media        <= media_next;
            o_media_valida <= 1'b1;
            case (state)
                FILLING: begin
                    // Counter stops at the window length once the FSM leaves FILLING.
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt + 1'b1 == WINDOW) begin
                        state          <= RUNNING;
                        o_janela_cheia <= 1'b1;
                    end
                end
                RUNNING: begin
                    o_janela_cheia <= 1'b1;
                end
                default: begin
                    state <= FILLING;
                end
            endcase
        end else begin
            o_media_valida <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Randomized and directed checks of moving_average_filter against a window-queue model.
module tb_moving_average_filter;

    localparam int DW = 4;
    localparam int WL = 2;
    localparam int W  = 1 << WL;

    logic          clk_fpga;
    logic          reset_n;
    logic [DW-1:0] i_dado;
    logic          i_dado_valido;
    logic          i_clear;
    logic [DW-1:0] o_media;
    logic          o_media_valida;
    logic [DW+WL-1:0] o_soma;
    logic          o_janela_cheia;

    int compared;
    int mismatched;

    int window_q[$];
    int accepted;
    int exp_media;
    int exp_soma;
    int exp_valid;
    int exp_full;

    moving_average_filter #(
        .DATA_WIDTH  (DW),
        .WINDOW_LOG2 (WL)
    ) dut (
        .clk_fpga       (clk_fpga),
        .reset_n        (reset_n),
        .i_dado         (i_dado),
        .i_dado_valido  (i_dado_valido),
        .i_clear        (i_clear),
        .o_media        (o_media),
        .o_media_valida (o_media_valida),
        .o_soma         (o_soma),
        .o_janela_cheia (o_janela_cheia)
    );

    initial clk_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        window_q.delete();
        for (int i = 0; i < W; i++) window_q.push_back(0);
        accepted  = 0;
        exp_media = 0;
        exp_soma  = 0;
        exp_valid = 0;
        exp_full  = 0;
    endtask

    // Average is the zero-padded window total divided by W, rounded half up.
    task automatic modelStep(input int valid, input int data, input int clear);
        int total;
        if (clear != 0) begin
            modelReset();
        end else if (valid != 0) begin
            window_q.push_back(data);
            void'(window_q.pop_front());
            total = 0;
            foreach (window_q[i]) total += window_q[i];
            accepted++;
            exp_soma  = total;
            exp_media = (total + W / 2) / W;
            exp_valid = 1;
            exp_full  = (accepted >= W) ? 1 : 0;
        end else begin
            exp_valid = 0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_valida"}, int'(o_media_valida), exp_valid);
        checkOutput({tag, "_media"},  int'(o_media),        exp_media);
        checkOutput({tag, "_soma"},   int'(o_soma),         exp_soma);
        checkOutput({tag, "_cheia"},  int'(o_janela_cheia), exp_full);
    endtask

    task automatic applyStimulus(input int valid, input int data, input int clear, input string tag);
        @(negedge clk_fpga);
        i_dado_valido = (valid != 0);
        i_dado        = DW'(data);
        i_clear       = (clear != 0);
        @(posedge clk_fpga);
        #1;
        modelStep(valid, data, clear);
        checkAll(tag);
    endtask

    task automatic doReset();
        @(negedge clk_fpga);
        reset_n       = 1'b0;
        i_dado_valido = 1'b0;
        i_clear       = 1'b0;
        i_dado        = '0;
        modelReset();
        #1;
        checkAll("reset");
        @(negedge clk_fpga);
        reset_n = 1'b1;
    endtask

    initial begin
        int fill_data[4];
        int run_data[3];
        int hold_media;
        int hold_soma;

        compared      = 0;
        mismatched    = 0;
        reset_n       = 1'b0;
        i_dado        = '0;
        i_dado_valido = 1'b0;
        i_clear       = 1'b0;
        modelReset();

        #12;
        checkAll("por");
        doReset();

        fill_data = '{4, 8, 12, 15};
        foreach (fill_data[i]) begin
            applyStimulus(1, fill_data[i], 0, "fill");
            applyStimulus(0, 0, 0, "fill_gap");
        end
        checkOutput("plan_fill_media", int'(o_media), 10);
        checkOutput("plan_fill_soma", int'(o_soma), 39);
        checkOutput("plan_fill_cheia", int'(o_janela_cheia), 1);

        run_data = '{0, 0, 15};
        foreach (run_data[i]) applyStimulus(1, run_data[i], 0, "wrap");
        checkOutput("plan_wrap_soma", int'(o_soma), 30);
        checkOutput("plan_wrap_media", int'(o_media), 8);

        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 15, 0, "b2b");
        checkOutput("plan_b2b_media", int'(o_media), 15);

        applyStimulus(1, 7, 1, "clear_hit");
        checkOutput("plan_clear_soma", int'(o_soma), 0);
        applyStimulus(0, 0, 0, "clear_idle");
        applyStimulus(1, 7, 0, "clear_next");
        checkOutput("plan_clear_media", int'(o_media), 2);
        checkOutput("plan_clear_soma7", int'(o_soma), 7);

        for (int i = 0; i < 3; i++) applyStimulus(1, 9 + i, 0, "burst");
        @(negedge clk_fpga);
        i_dado_valido = 1'b1;
        i_dado        = 4'd13;
        @(posedge clk_fpga);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkAll("async_rst");
        @(negedge clk_fpga);
        i_dado_valido = 1'b0;
        reset_n       = 1'b1;
        applyStimulus(1, 8, 0, "post_rst");
        checkOutput("plan_post_rst_media", int'(o_media), 2);

        hold_media = int'(o_media);
        hold_soma  = int'(o_soma);
        for (int i = 0; i < 20; i++) applyStimulus(0, int'($urandom_range(0, 15)), 0, "idle");
        checkOutput("plan_idle_media", int'(o_media), hold_media);
        checkOutput("plan_idle_soma", int'(o_soma), hold_soma);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 70) ? 1 : 0,
                          int'($urandom_range(0, 15)),
                          ($urandom_range(0, 99) < 4) ? 1 : 0,
                          "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/moving_average_filter.md
Name: moving_average_filter

Overview:
- Downstream consumer of the handshake receiver stage.
- Takes each validated sample (data bus plus one-cycle "new data ready" strobe) and produces a rounded running average over the last 2^WINDOW_LOG2 samples.
- Output is a one-cycle-valid result for the next filter/display stage.
- Internals: circular sample buffer, incremental accumulator, fill-state FSM.

Parameters:
- DATA_WIDTH, 4, sample and average width in bits.
- WINDOW_LOG2, 2, log2 of window length W (W = 4 by default); legal range 1..6.

Ports:
- clk_fpga  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_dado  input  DATA_WIDTH  sample, unsigned, valid only when i_dado_valido=1.
- i_dado_valido  input  1  single-cycle strobe, may be asserted every cycle.
- i_clear  input  1  synchronous flush of the window.
- o_media  output  DATA_WIDTH  rounded average.
- o_media_valida  output  1  single-cycle strobe qualifying o_media.
- o_soma  output  DATA_WIDTH+WINDOW_LOG2  current window sum (debug/downstream use).
- o_janela_cheia  output  1  high once W samples have been accepted since reset/clear.

Behaviour:
- Reset (reset_n low, async): ring buffer entries=0, write pointer=0, fill counter=0, sum=0, FSM=FILLING.
- Reset values of outputs: o_media=0, o_media_valida=0, o_soma=0, o_janela_cheia=0.
- Reset asserted mid-operation discards all history; the first sample after release is treated as sample #1.
- FSM states:
  - FILLING: fill counter < W.
  - RUNNING: window full.
- FSM transitions:
  - FILLING -> RUNNING on the accepted sample that makes the counter reach W.
  - RUNNING -> FILLING only on i_clear.
  - The counter saturates at W.
- Accept (i_dado_valido=1, i_clear=0) in both states, in one cycle:
  - oldest = buf[wr_ptr]
  - buf[wr_ptr] <= i_dado
  - sum <= sum + i_dado - oldest
  - wr_ptr <= wr_ptr+1, wrapping W-1 -> 0 naturally on WINDOW_LOG2 bits.
- In FILLING, unwritten entries are 0, so the average is zero-padded (sum divided by W, not by count).
- Arithmetic:
  - sum is DATA_WIDTH+WINDOW_LOG2 bits unsigned and can never overflow or underflow, since the buffer holds exactly the summed samples.
  - o_media = (sum_next + 2^(WINDOW_LOG2-1)) >> WINDOW_LOG2 (round half up), computed in DATA_WIDTH+WINDOW_LOG2 bits.
  - The maximum result is 2^DATA_WIDTH-1, so no overflow.
- Latency: o_media, o_soma and o_media_valida are registered and appear exactly 1 cycle after the accepting edge.
  - o_media_valida pulses once per accepted sample.
  - Back-to-back strobes yield back-to-back results.
- o_janela_cheia is registered and rises in the same cycle as the o_media_valida of the W-th sample.
- o_media and o_soma hold their last values between strobes.
- i_clear:
  - Zeroes buffer, sum, pointer and counter; FSM -> FILLING.
  - Next cycle: o_janela_cheia=0 and o_soma=0; o_media is also cleared to 0.
  - No o_media_valida is produced.
- i_clear and i_dado_valido in the same cycle: clear wins, the sample is dropped, no strobe follows.
- i_dado while i_dado_valido=0 is ignored, including X.

Decomposition:
- Package filter_pkg:
  - state_t enum {FILLING, RUNNING}.
  - Function for the rounding shift.
  - Localparam helper for SUM_WIDTH = DATA_WIDTH+WINDOW_LOG2.
- Sub-module sample_ring_buffer (DATA_WIDTH, WINDOW_LOG2):
  - Register array, wr_ptr, write enable and clear.
  - Returns the oldest entry combinationally.
- The top level holds the FSM, fill counter, accumulator and output registers.

Test Plan (DATA_WIDTH=4, WINDOW_LOG2=2):
- Fill: strobes with 4, 8, 12, 15 on separate cycles -> o_media 1, 3, 6, 10; o_soma 4, 12, 24, 39; o_janela_cheia rises with the 4th result.
- Steady state/wrap: continue with 0, 0, 15 -> o_soma 35, 27, 30; o_media 9, 7, 8; the pointer wraps without glitch.
- Back-to-back: strobes with 15 on 8 consecutive cycles from reset -> 8 consecutive o_media_valida pulses; o_media 4, 8, 11, 15, 15, 15, 15, 15.
- Clear collision: window full of 15, then i_clear=1 with i_dado_valido=1 and i_dado=7 -> no strobe; o_soma=0, o_janela_cheia=0; next sample 7 -> o_media 2, o_soma 7.
- Async reset mid-run: drop reset_n between clock edges during a strobe burst -> all outputs 0 immediately without a clock edge; after release, sample 8 -> o_media 2.
- Idle hold: no strobes for 20 cycles with toggling i_dado -> o_media and o_soma unchanged; o_media_valida stays 0.
